// File: rtl/matrix_capture.sv
// Receive-side stand-in for the LED-matrix shift-register interface: deserializes
// the row and column chains and rebuilds the displayed frame into a readable buffer.
module matrix_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int ROWS        = 16,
  parameter int COLS        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rclk,
  input  logic                    rsdi,
  input  logic                    oeb,
  input  logic                    csdi,
  input  logic                    cclk,
  input  logic                    le,
  input  logic [$clog2(ROWS)-1:0] rd_addr,
  output logic [COLS-1:0]         rd_data,
  output logic                    frame_done,
  output logic [7:0]              frame_count,
  output logic                    err_row
);

  localparam int AW    = $clog2(ROWS);
  localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // Bit positions of the interface inputs inside the synchronizer vector.
  localparam int I_RSDI = 0;
  localparam int I_RCLK = 1;
  localparam int I_CSDI = 2;
  localparam int I_CCLK = 3;
  localparam int I_LE   = 4;
  localparam int I_OEB  = 5;
  localparam logic [5:0] IDLE_LEVELS = 6'b100000;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  logic [5:0]      raw_in;
  logic [5:0]      sync_q [NSYNC];
  logic [5:0]      sync_s;
  logic            rclk_q, cclk_q, le_q, oeb_q;
  logic            rclk_rise, cclk_rise, le_rise, oeb_fall;

  logic [ROWS-1:0] row_sr;
  logic [COLS-1:0] col_sr;
  logic [COLS-1:0] col_latch;
  logic [COLS-1:0] latch_next;
  logic [COLS-1:0] frame [ROWS];
  logic [0:0]      state;

  logic            row_onehot;
  logic [AW-1:0]   row_idx;
  logic            armed_now;
  logic            commit_ok;
  logic            commit_bad;
  logic            last_row;

  assign raw_in = {oeb, le, cclk, csdi, rclk, rsdi};
  assign sync_s = sync_q[NSYNC-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSYNC; i++) sync_q[i] <= IDLE_LEVELS;
      rclk_q <= 1'b0;
      cclk_q <= 1'b0;
      le_q   <= 1'b0;
      oeb_q  <= 1'b1;
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < NSYNC; i++) sync_q[i] <= sync_q[i-1];
      rclk_q <= sync_s[I_RCLK];
      cclk_q <= sync_s[I_CCLK];
      le_q   <= sync_s[I_LE];
      oeb_q  <= sync_s[I_OEB];
    end
  end

  assign rclk_rise = sync_s[I_RCLK] & ~rclk_q;
  assign cclk_rise = sync_s[I_CCLK] & ~cclk_q;
  assign le_rise   = sync_s[I_LE]   & ~le_q;
  assign oeb_fall  = ~sync_s[I_OEB] &  oeb_q;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    latch_next = le_rise ? col_sr : col_latch;
    row_onehot = $onehot(row_sr);
    row_idx    = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_sr[i]) row_idx = AW'(i);
    end
    // An le edge arriving with the oeb fall arms and commits in the same cycle.
    armed_now  = (state == ST_ARMED) || le_rise;
    commit_ok  = oeb_fall && armed_now && row_onehot;
    commit_bad = oeb_fall && armed_now && !row_onehot;
    last_row   = (row_idx == AW'(ROWS-1));
  end

  // Shift chains and column latch; a simultaneous cclk/le edge latches the
  // pre-shift chain because both read the old col_sr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_sr    <= '0;
      col_sr    <= '0;
      col_latch <= '0;
      state     <= ST_IDLE;
    end else begin
      if (rclk_rise) row_sr <= {row_sr[ROWS-2:0], sync_s[I_RSDI]};
      if (cclk_rise) col_sr <= {col_sr[COLS-2:0], sync_s[I_CSDI]};
      col_latch <= latch_next;
      if (le_rise) state <= ST_ARMED;
    end
  end

  // NOTE: the frame buffer is built from flops and cleared by reset so a bench
  // can compare every pixel right after reset; this rules out block RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) frame[r] <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= frame[rd_addr];
      if (commit_ok) frame[row_idx] <= latch_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done  <= 1'b0;
      frame_count <= '0;
      err_row     <= 1'b0;
    end else begin
      frame_done <= commit_ok && last_row;
      if (commit_ok && last_row) frame_count <= frame_count + 8'd1;
      if (commit_bad) err_row <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_capture.sv
// Self-checking bench for matrix_capture: table-driven vectors, hand-written
// corner sequences and a randomized run against a transaction-level frame model.
module tb_matrix_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        rclk, rsdi, oeb, csdi, cclk, le;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        err_row;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  matrix_capture #(.SYNC_STAGES(2), .ROWS(16), .COLS(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .rclk        (rclk),
    .rsdi        (rsdi),
    .oeb         (oeb),
    .csdi        (csdi),
    .cclk        (cclk),
    .le          (le),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .err_row     (err_row)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] row;
    logic [15:0] cols;
    logic        do_le;
    logic [3:0]  addr;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  // Reference model for the randomized section.
  logic [15:0] m_frame [16];
  logic [15:0] m_latch;
  logic        m_err;
  logic        m_armed;
  int          m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic shift_cols(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) begin
      csdi = v[i];
      idle(2);
      cclk = 1'b1;
      idle(3);
      cclk = 1'b0;
      idle(2);
    end
  endtask

  task automatic shift_rows(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) begin
      rsdi = v[i];
      idle(2);
      rclk = 1'b1;
      idle(3);
      rclk = 1'b0;
      idle(2);
    end
  endtask

  task automatic pulse_le();
    le = 1'b1;
    idle(3);
    le = 1'b0;
    idle(3);
  endtask

  task automatic commit();
    oeb = 1'b0;
    idle(3);
    oeb = 1'b1;
    idle(3);
  endtask

  task automatic transaction(input logic [15:0] row, input logic [15:0] cols);
    shift_cols(cols);
    pulse_le();
    shift_rows(row);
    commit();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [15:0] exp, input string name);
    rd_addr = a;
    idle(1);
    check(name, {16'h0, rd_data}, {16'h0, exp});
  endtask

  initial begin
    logic [15:0] v, c, rv;
    int d0, kind, a, idx;
    logic do_le;

    reset = 1'b1; rclk = 1'b0; rsdi = 1'b0; oeb = 1'b1;
    csdi = 1'b0; cclk = 1'b0; le = 1'b0; rd_addr = '0;
    idle(2);
    reset = 1'b0;
    idle(2);

    // Reset state.
    for (int k = 0; k < 16; k++) do_read(4'(k), 16'h0000, "reset_rd");
    check("reset_count", {24'h0, frame_count}, 32'd0);
    check("reset_err", {31'h0, err_row}, 32'd0);
    check("reset_done", done_cnt, 0);

    // oeb fall while still IDLE: no err even with an all-zero row chain.
    shift_rows(16'h0000);
    commit();
    check("idle_no_err", {31'h0, err_row}, 32'd0);

    // Table-driven transactions, applied in order from a fresh reset.
    vecs[0] = '{16'h0008, 16'hA5C3, 1'b1, 4'd3,  16'hA5C3, 1'b0};
    vecs[1] = '{16'h0001, 16'h1234, 1'b1, 4'd0,  16'h1234, 1'b0};
    vecs[2] = '{16'h0100, 16'hFFFF, 1'b1, 4'd8,  16'hFFFF, 1'b0};
    vecs[3] = '{16'h0400, 16'h5A5A, 1'b0, 4'd10, 16'hFFFF, 1'b0};
    vecs[4] = '{16'h0001, 16'h0000, 1'b1, 4'd3,  16'hA5C3, 1'b0};
    vecs[5] = '{16'h0000, 16'h7777, 1'b1, 4'd0,  16'h0000, 1'b1};
    vecs[6] = '{16'h0011, 16'h7777, 1'b1, 4'd4,  16'h0000, 1'b1};
    vecs[7] = '{16'h0080, 16'h0F0F, 1'b1, 4'd7,  16'h0F0F, 1'b1};
    apply_reset();
    for (int t = 0; t < 8; t++) begin
      shift_cols(vecs[t].cols);
      if (vecs[t].do_le) pulse_le();
      shift_rows(vecs[t].row);
      commit();
      do_read(vecs[t].addr, vecs[t].exp_data, "vec_rd");
      check("vec_err", {31'h0, err_row}, {31'h0, vecs[t].exp_err});
    end
    do_read(4'd0, 16'h0000, "vec_row0_kept");
    do_read(4'd6, 16'h0000, "vec_row6_untouched");
    do_read(4'd2, 16'h0000, "vec_row2_untouched");

    // Full frame: diagonal pattern, frame_done exactly once on row 15.
    apply_reset();
    d0 = done_cnt;
    for (int r = 0; r < 16; r++) begin
      v = 16'h0001 << r;
      transaction(v, v);
      if (r == 14) check("no_early_done", done_cnt - d0, 0);
    end
    check("frame_done_once", done_cnt - d0, 1);
    check("frame_count_1", {24'h0, frame_count}, 32'd1);
    for (int k = 0; k < 16; k++) do_read(4'(k), 16'h0001 << k, "frame_rd");

    // Asynchronous reset in the middle of a row shift.
    rsdi = 1'b1;
    for (int i = 0; i < 7; i++) begin
      idle(2); rclk = 1'b1; idle(3); rclk = 1'b0; idle(2);
    end
    rclk = 1'b1;
    idle(1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rd_data", {16'h0, rd_data}, 32'd0);
    check("async_count", {24'h0, frame_count}, 32'd0);
    check("async_done", {31'h0, frame_done}, 32'd0);
    check("async_err", {31'h0, err_row}, 32'd0);
    rclk = 1'b0;
    rsdi = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(2);
    transaction(16'h0004, 16'hC0DE);
    for (int k = 0; k < 16; k++) do_read(4'(k), (k == 2) ? 16'hC0DE : 16'h0000, "post_reset_rd");
    check("post_reset_count", {24'h0, frame_count}, 32'd0);

    // Same-cycle events: le rise with oeb fall uses the freshly latched value.
    apply_reset();
    pulse_le();
    shift_cols(16'hFFFF);
    shift_rows(16'h0020);
    le = 1'b1;
    oeb = 1'b0;
    idle(3);
    le = 1'b0;
    oeb = 1'b1;
    idle(3);
    do_read(4'd5, 16'hFFFF, "bypass_le_oeb");
    // cclk and le together: latch holds the pre-shift chain.
    csdi = 1'b0;
    idle(2);
    cclk = 1'b1;
    le = 1'b1;
    idle(3);
    cclk = 1'b0;
    le = 1'b0;
    idle(3);
    commit();
    do_read(4'd5, 16'hFFFF, "cclk_le_preshift");
    pulse_le();
    commit();
    do_read(4'd5, 16'hFFFE, "cclk_le_shifted");

    // Randomized transactions against the frame model.
    apply_reset();
    for (int k = 0; k < 16; k++) m_frame[k] = '0;
    m_latch = '0; m_err = 1'b0; m_armed = 1'b0; m_count = 0;
    for (int t = 0; t < 40; t++) begin
      c    = 16'($urandom);
      kind = $urandom_range(0, 11);
      if (kind == 0)      rv = 16'h0000;
      else if (kind == 1) rv = 16'($urandom);
      else if (kind >= 9) rv = 16'h8000;
      else                rv = 16'h0001 << $urandom_range(0, 15);
      do_le = (t == 0) || ($urandom_range(0, 4) != 0);
      shift_cols(c);
      if (do_le) begin
        pulse_le();
        m_latch = c;
        m_armed = 1'b1;
      end
      shift_rows(rv);
      commit();
      if (m_armed) begin
        if ($countones(rv) == 1) begin
          idx = 0;
          for (int i = 0; i < 16; i++) if (rv[i]) idx = i;
          m_frame[idx] = m_latch;
          if (idx == 15) m_count = (m_count + 1) % 256;
        end else begin
          m_err = 1'b1;
        end
      end
      a = $urandom_range(0, 15);
      do_read(4'(a), m_frame[a], "rand_rd");
      check("rand_err", {31'h0, err_row}, {31'h0, m_err});
      check("rand_count", {24'h0, frame_count}, m_count);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/matrix_capture.md
Name: matrix_capture

Overview:
- Receive-side model of the LED-matrix shift-register interface driven by the screen block (RCLK/RSDI row chain, CCLK/CSDI column chain, LE latch, OEB output enable).
- Deserializes both chains and reconstructs the displayed 16x16 frame into an internal frame buffer, readable through a registered read port.
- Used in simulation benches and on FPGA bring-up as a stand-in for the physical matrix, so screen, game and paddle behaviour can be checked pixel-exactly.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on each of the six interface inputs (minimum 2).
- ROWS, 16: matrix rows; also the row-chain length.
- COLS, 16: matrix columns; also the column-chain length.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rclk  input  1  row shift clock; rising edge shifts rsdi in.
- rsdi  input  1  row serial data.
- oeb  input  1  output enable, active low.
- csdi  input  1  column serial data.
- cclk  input  1  column shift clock; rising edge shifts csdi in.
- le  input  1  column latch enable; rising edge latches the column chain.
- rd_addr  input  4  frame-buffer row to read.
- rd_data  output  16  frame-buffer row contents; bit i = column i lit.
- frame_done  output  1  one-cycle pulse after row ROWS-1 is committed.
- frame_count  output  8  count of completed frames; wraps 255->0.
- err_row  output  1  sticky flag: row chain was not one-hot at a commit.

Behaviour:
- Reset (async, active-high) clears:
  - synchronizers, plus edge-detect history to rclk=cclk=le=0 and oeb=1;
  - row_sr, col_sr, col_latch and all frame-buffer rows to 0;
  - rd_data=0, frame_done=0, frame_count=0, err_row=0.
- Reset mid-frame discards partial data. After release, the first commit happens only on a fresh oeb falling edge.
- Synchronizing and edge detection:
  - Every input passes through SYNC_STAGES flops.
  - Edges are detected on the synchronized value against the previous synchronized value.
  - The driver must hold each level for at least 2 clk cycles.
  - Input-to-internal-effect latency is SYNC_STAGES+1 cycles.
- Shifting:
  - rclk rising: row_sr <= {row_sr[ROWS-2:0], rsdi_s}.
  - cclk rising: col_sr <= {col_sr[COLS-2:0], csdi_s}. The first bit shifted ends at bit COLS-1.
- Latching:
  - le rising: col_latch <= col_sr.
  - cclk and le rising in the same cycle: col_latch takes the pre-shift col_sr.
- Commit, on oeb falling edge (display enabled):
  - If row_sr is one-hot with bit r set: frame[r] <= col_latch.
  - If row_sr is not one-hot (zero or multi-hot): no write, err_row <= 1. err_row is cleared only by reset.
  - le rising and oeb falling in the same cycle: the commit uses the newly latched value (bypass).
- Frame completion:
  - A successful commit to row ROWS-1 pulses frame_done for exactly 1 cycle, on the cycle after the write.
  - frame_count increments on that same cycle.
  - Rows written out of order still complete a frame on row ROWS-1. No ordering check is made.
- Read port:
  - rd_data <= frame[rd_addr], 1-cycle latency.
  - A read and a commit to the same row in the same cycle return the old contents (read-before-write).
- Ignored activity:
  - rclk/cclk/le activity while oeb is low is still shifted or latched.
  - oeb rising edges have no effect.
- State machine, IDLE -> ARMED -> (commit) -> ARMED:
  - IDLE: after reset, until the first le rising edge. An oeb fall while IDLE writes nothing and does not set err_row.
  - ARMED: commits are evaluated as described above.

Test Plan:
- Reset then read all 16 rows: every rd_data=16'h0000; frame_done never pulses; frame_count=0; err_row=0.
- Shift 16'hA5C3 on csdi (MSB first), pulse le, shift row one-hot 16'h0008, drop oeb: rd_addr=3 returns 16'hA5C3 one cycle later; other rows 0.
- Full frame: for r=0..15 load cols=16'h0001<<r with row bit r and commit: after r=15, frame_done high exactly 1 cycle and frame_count=1; rd_addr=k returns 1<<k for every k.
- Row chain 16'h0000, then 16'h0011, each followed by an oeb fall: no frame write, err_row=1 and stays 1 through further valid commits until reset.
- Same-cycle events: le rise together with oeb fall, with row 5 selected and col_sr=16'hFFFF: frame[5]=16'hFFFF. cclk and le rise together: latched value excludes the new bit.
- Assert reset mid-row-shift after 7 rclk pulses: all outputs return to reset values immediately (asynchronous). After release, a complete row-2 transaction writes only frame[2].
